// File: rtl/pixel_dispatcher.sv
// Raster-order pixel job issuer feeding up to four ray-tracing cores in strict round-robin.
// The core rotation survives across frames so a result collector can follow the same order.
module pixel_dispatcher #(
  parameter int WIDTH_X = 10,
  parameter int WIDTH_Y = 10
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_X-1:0] frame_width,
  input  logic [WIDTH_Y-1:0] frame_height,
  input  logic [2:0]         no_of_extra_cores,
  input  logic               job_ready_1,
  input  logic               job_ready_2,
  input  logic               job_ready_3,
  input  logic               job_ready_4,
  output logic               job_valid_1,
  output logic               job_valid_2,
  output logic               job_valid_3,
  output logic               job_valid_4,
  output logic [WIDTH_X-1:0] job_x,
  output logic [WIDTH_Y-1:0] job_y,
  output logic               job_last,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH_X-1:0] X_ONE = WIDTH_X'(1);
  localparam logic [WIDTH_Y-1:0] Y_ONE = WIDTH_Y'(1);

  state_t             state_q, state_d;
  logic [WIDTH_X-1:0] x_q, x_d, width_q, width_d;
  logic [WIDTH_Y-1:0] y_q, y_d, height_q, height_d;
  logic [1:0]         idx_q, idx_d;
  logic [2:0]         ncores_q, ncores_d;
  logic [3:0]         valid_q, valid_d;
  logic               last_q, last_d, busy_q, busy_d, done_q, done_d;

  logic [3:0]         ready;
  logic               hs;
  logic [2:0]         ncores_start;
  logic [1:0]         idx_start, idx_next;
  logic               x_wrap;
  logic [WIDTH_X-1:0] x_nx;
  logic [WIDTH_Y-1:0] y_nx;

  assign ready        = {job_ready_4, job_ready_3, job_ready_2, job_ready_1};
  assign hs           = |(valid_q & ready);
  assign ncores_start = (no_of_extra_cores > 3'd3) ? 3'd4 : no_of_extra_cores + 3'd1;
  assign idx_start    = ({1'b0, idx_q} >= ncores_start) ? 2'd0 : idx_q;
  assign idx_next     = (({1'b0, idx_q} + 3'd1) == ncores_q) ? 2'd0 : idx_q + 2'd1;
  // Compare against width-1 so a full-range width never needs x to count past its maximum.
  assign x_wrap       = (x_q == width_q - X_ONE);
  assign x_nx         = x_wrap ? '0 : x_q + X_ONE;
  assign y_nx         = x_wrap ? y_q + Y_ONE : y_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;
    idx_d    = idx_q;
    ncores_d = ncores_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          width_d  = frame_width;
          height_d = frame_height;
          ncores_d = ncores_start;
          idx_d    = idx_start;
          x_d      = '0;
          y_d      = '0;
          busy_d   = 1'b1;
          if (frame_width == '0 || frame_height == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            valid_d = 4'b0001 << idx_start;
            last_d  = (frame_width == X_ONE) && (frame_height == Y_ONE);
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          idx_d = idx_next;
          if (last_q) begin
            state_d = DONE;
            valid_d = 4'b0000;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d     = x_nx;
            y_d     = y_nx;
            valid_d = 4'b0001 << idx_next;
            last_d  = (x_nx == width_q - X_ONE) && (y_nx == height_q - Y_ONE);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      idx_d   = 2'd0;
      valid_d = 4'b0000;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      idx_q    <= 2'd0;
      ncores_q <= 3'd0;
      valid_q  <= 4'b0000;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      idx_q    <= idx_d;
      ncores_q <= ncores_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign job_valid_1 = valid_q[0];
  assign job_valid_2 = valid_q[1];
  assign job_valid_3 = valid_q[2];
  assign job_valid_4 = valid_q[3];
  assign job_x       = x_q;
  assign job_y       = y_q;
  assign job_last    = last_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomized bench for pixel_dispatcher: a frame-level model (job index k -> x=k%w, y=k/w,
// core rotation mod ncores) is compared every cycle, plus literal job-sequence pins.
module tb_pixel_dispatcher;
  localparam int WX = 10;
  localparam int WY = 10;

  logic          aclk = 1'b0;
  logic          areset, start, abort;
  logic [WX-1:0] frame_width;
  logic [WY-1:0] frame_height;
  logic [2:0]    no_of_extra_cores;
  logic          job_ready_1, job_ready_2, job_ready_3, job_ready_4;
  logic          job_valid_1, job_valid_2, job_valid_3, job_valid_4;
  logic [WX-1:0] job_x;
  logic [WY-1:0] job_y;
  logic          job_last, busy, frame_done;

  pixel_dispatcher #(.WIDTH_X(WX), .WIDTH_Y(WY)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .frame_width(frame_width), .frame_height(frame_height),
    .no_of_extra_cores(no_of_extra_cores),
    .job_ready_1(job_ready_1), .job_ready_2(job_ready_2),
    .job_ready_3(job_ready_3), .job_ready_4(job_ready_4),
    .job_valid_1(job_valid_1), .job_valid_2(job_valid_2),
    .job_valid_3(job_valid_3), .job_valid_4(job_valid_4),
    .job_x(job_x), .job_y(job_y), .job_last(job_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1 issuing, 2 frame-done cycle
  int m_phase = 0, m_core = 0, m_k = 0, m_w = 0, m_h = 0, m_nc = 1;

  typedef struct {int core; int x; int y; int last;} job_t;
  job_t log_q[$];
  int   done_cnt, nsteps;

  logic [3:0]    pv;
  logic [WX-1:0] px;
  logic [WY-1:0] py;
  logic          plast;

  task automatic sample();
    pv    = {job_valid_4, job_valid_3, job_valid_2, job_valid_1};
    px    = job_x;
    py    = job_y;
    plast = job_last;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic void model_edge(input bit st, input bit ab, input logic [3:0] rdy);
    if (ab) begin
      m_phase = 0;
      m_core  = 0;
    end else begin
      case (m_phase)
        0: if (st) begin
          m_w  = int'(frame_width);
          m_h  = int'(frame_height);
          m_nc = (no_of_extra_cores > 3) ? 4 : int'(no_of_extra_cores) + 1;
          if (m_core >= m_nc) m_core = 0;
          m_k     = 0;
          m_phase = (m_w * m_h == 0) ? 2 : 1;
        end
        1: if (rdy[m_core]) begin
          m_core = (m_core + 1) % m_nc;
          m_k++;
          if (m_k == m_w * m_h) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endfunction

  task automatic check_outputs();
    logic [3:0] ev;
    int ex, ey;
    bit el, ok;
    ev = (m_phase == 1) ? (4'b0001 << m_core) : 4'b0000;
    ex = (m_phase == 1) ? m_k % m_w : 0;
    ey = (m_phase == 1) ? m_k / m_w : 0;
    el = (m_phase == 1) && (m_k == m_w * m_h - 1);
    ok = (pv == ev) && (busy == (m_phase != 0)) && (frame_done == (m_phase == 2)) &&
         (plast == el) && (ev == 0 || (int'(px) == ex && int'(py) == ey));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cycle t=%0t got v=%b busy=%b done=%b last=%b x=%0d y=%0d want v=%b busy=%b done=%b last=%b x=%0d y=%0d",
               $time, pv, busy, frame_done, plast, px, py, ev, m_phase != 0, m_phase == 2, el, ex, ey);
    end
  endtask

  task automatic step(input bit st, input bit ab, input logic [3:0] rdy);
    job_t j;
    start = st;
    abort = ab;
    {job_ready_4, job_ready_3, job_ready_2, job_ready_1} = rdy;
    @(posedge aclk);
    if ((pv & rdy) != 4'b0000) begin
      j.core = 0;
      for (int i = 3; i >= 0; i--) if (pv[i] && rdy[i]) j.core = i + 1;
      j.x = int'(px);
      j.y = int'(py);
      j.last = int'(plast);
      log_q.push_back(j);
    end
    model_edge(st, ab, rdy);
    #1;
    if (frame_done) done_cnt++;
    sample();
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    start = 1'b0;
    abort = 1'b0;
    areset = 1'b1;
    #1;
    lit("async_reset_outputs",
        int'({job_valid_4, job_valid_3, job_valid_2, job_valid_1, job_last, busy, frame_done}) +
        int'(job_x) + int'(job_y), 0);
    m_phase = 0;
    m_core  = 0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    sample();
    check_outputs();
  endtask

  function automatic int seq(input int f);
    int r = 0;
    for (int i = 0; i < log_q.size() && i < 8; i++)
      case (f)
        0: r = r * 16 + log_q[i].core;
        1: r = r * 16 + log_q[i].x;
        2: r = r * 16 + log_q[i].y;
        default: r = r * 16 + log_q[i].last;
      endcase
    return r;
  endfunction

  // mode: 0 all ready, 1 random, 2 core-2 stall, 3 restarts while busy, 4 abort, 5 areset
  task automatic run_frame(input int w, input int h, input int e, input int mode);
    int stall = 0, limit;
    bit fired = 0, st, ab;
    logic [3:0] rdy;
    frame_width = w[WX-1:0];
    frame_height = h[WY-1:0];
    no_of_extra_cores = e[2:0];
    log_q.delete();
    done_cnt = 0;
    nsteps = 0;
    limit = 40 * w * h + 40;
    step(1'b1, 1'b0, 4'b1111);
    while (m_phase != 0 && nsteps < limit) begin
      rdy = 4'b1111;
      st = 1'b0;
      ab = 1'b0;
      case (mode)
        1: begin
          rdy = 4'($urandom);
          st  = ($urandom_range(7) == 0);
          ab  = ($urandom_range(59) == 0);
          if ($urandom_range(3) == 0) frame_width = WX'($urandom_range(6));
        end
        2: if (m_phase == 1 && m_core == 1 && stall < 5) begin
          rdy = 4'b1101;
          stall++;
        end
        3: begin
          st = ($urandom_range(2) == 0);
          frame_width = WX'($urandom);
          no_of_extra_cores = 3'($urandom);
        end
        4: if (!fired && m_phase == 1 && m_core == 2) begin
          ab = 1'b1;
          fired = 1'b1;
        end
        default: ;
      endcase
      if (mode == 5 && !fired && m_phase == 1 && m_core == 2) begin
        fired = 1'b1;
        async_reset();
      end else begin
        step(st, ab, rdy);
        nsteps++;
      end
    end
    if (m_phase != 0) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout w=%0d h=%0d got_steps=%0d want_below=%0d", w, h, nsteps, limit);
    end
    step(1'b0, 1'b0, 4'b1111);
  endtask

  initial begin
    areset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    frame_width = '0;
    frame_height = '0;
    no_of_extra_cores = 3'd0;
    {job_ready_4, job_ready_3, job_ready_2, job_ready_1} = 4'b0000;
    #1;
    lit("reset_outputs",
        int'({job_valid_4, job_valid_3, job_valid_2, job_valid_1, job_last, busy, frame_done}) +
        int'(job_x) + int'(job_y), 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    sample();
    check_outputs();

    run_frame(4, 2, 3, 0);
    lit("t1_cores", seq(0), 32'h12341234);
    lit("t1_x", seq(1), 32'h01230123);
    lit("t1_y", seq(2), 32'h00001111);
    lit("t1_last", seq(3), 32'h00000001);
    lit("t1_steps", nsteps, 9);
    lit("t1_done", done_cnt, 1);

    run_frame(3, 1, 1, 0);
    lit("t2a_cores", seq(0), 32'h121);
    run_frame(3, 1, 1, 0);
    lit("t2b_cores", seq(0), 32'h212);

    run_frame(4, 2, 3, 2);
    lit("t3_cores", seq(0), 32'h12341234);
    lit("t3_steps", nsteps, 14);

    run_frame(0, 5, 3, 0);
    lit("t4_jobs", log_q.size(), 0);
    lit("t4_steps", nsteps, 1);
    lit("t4_done", done_cnt, 1);

    run_frame(5, 1, 6, 3);
    lit("t5_cores", seq(0), 32'h12341);
    lit("t5_jobs", log_q.size(), 5);

    run_frame(4, 2, 3, 5);
    run_frame(4, 1, 3, 0);
    lit("t6_reset_cores", seq(0), 32'h1234);
    lit("t6_reset_x", seq(1), 32'h0123);

    run_frame(4, 2, 3, 4);
    lit("t6_abort_done", done_cnt, 0);
    run_frame(4, 1, 3, 0);
    lit("t6_abort_cores", seq(0), 32'h1234);

    run_frame(1, 1, 0, 0);
    lit("one_px_jobs", log_q.size(), 1);
    lit("one_px_last", seq(3), 1);

    run_frame(1023, 2, 3, 0);
    lit("maxw_jobs", log_q.size(), 2046);
    lit("maxw_last_x", log_q[log_q.size()-1].x, 1022);
    lit("maxw_last_flag", log_q[log_q.size()-1].last, 1);
    run_frame(1, 1023, 2, 0);
    lit("maxh_jobs", log_q.size(), 1023);
    lit("maxh_last_y", log_q[log_q.size()-1].y, 1022);

    for (int f = 0; f < 40; f++)
      run_frame($urandom_range(6), $urandom_range(4), $urandom_range(7), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
